cart_mem_arbiter: RTL

//  Shares the single-port cartridge BRAM between the HPS ROM loader (ioctl writes) and the
//  A2601 core fetch path (reads). Core reads win every cycle; loader writes are buffered one

---
 rtl/cart_mem_arbiter.sv | 161 ++++++++++++++++
 1 files changed

// File: rtl/cart_mem_arbiter.sv
// Cartridge BRAM arbiter: core reads always win, loader writes wait in a one-deep buffer.
// Optional byte checksum of each download is built when CART_CHECKSUM_EN is defined.
module cart_mem_arbiter #(
  parameter int ADDR_W = 16,
  parameter int DATA_W = 8
) (
  input  logic              clk_sys,
  input  logic              reset_n,
  input  logic              ioctl_download,
  input  logic              ioctl_wr,
  input  logic [ADDR_W-1:0] ioctl_addr,
  input  logic [DATA_W-1:0] ioctl_dout,
  output logic              ioctl_wait,
  input  logic              core_rd,
  input  logic [ADDR_W-1:0] core_addr,
  output logic [DATA_W-1:0] core_data,
  output logic              core_valid,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_we,
  output logic [DATA_W-1:0] mem_din,
  input  logic [DATA_W-1:0] mem_dout,
  output logic [ADDR_W:0]   cart_size,
  output logic              loading,
  output logic [15:0]       cart_sum
);

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_LOAD  = 2'd1;
  localparam logic [1:0] ST_DRAIN = 2'd2;

  logic [1:0]        state_q, state_d;
  logic              dl_q;
  logic              rise_pend_q, rise_pend_d;
  logic              buf_full_q, buf_full_d;
  logic [ADDR_W-1:0] buf_addr_q, buf_addr_d;
  logic [DATA_W-1:0] buf_data_q, buf_data_d;
  logic              wait_q, wait_d;
  logic              rd_p1_q;
  logic              vld_p2_q;
  logic [DATA_W-1:0] data_p2_q, data_p2_d;
  logic [ADDR_W:0]   tracker_q, tracker_d;
  logic [ADDR_W:0]   size_q, size_d;
  logic              dl_rise, commit, buf_load, start_load;

  // Size is one past the highest written address, so it needs the extra bit.
  function automatic logic [ADDR_W:0] track_max(input logic [ADDR_W:0]   cur,
                                                input logic [ADDR_W-1:0] addr);
    logic [ADDR_W:0] nxt;
    nxt = {1'b0, addr} + {{ADDR_W{1'b0}}, 1'b1};
    return (nxt > cur) ? nxt : cur;
  endfunction

  assign dl_rise    = ioctl_download & ~dl_q;
  assign commit     = ~core_rd & buf_full_q;
  assign buf_load   = (state_q == ST_LOAD) & ioctl_wr & ~buf_full_q;
  assign start_load = (state_q == ST_IDLE) & (dl_rise | rise_pend_q);

  always_comb begin
    mem_addr = core_addr;
    mem_we   = 1'b0;
    mem_din  = '0;
    if (commit) begin
      mem_addr = buf_addr_q;
      mem_we   = 1'b1;
      mem_din  = buf_data_q;
    end
  end

  always_comb begin
    state_d     = state_q;
    rise_pend_d = rise_pend_q;
    size_d      = size_q;
    tracker_d   = commit ? track_max(tracker_q, buf_addr_q) : tracker_q;
    buf_full_d  = commit ? 1'b0 : (buf_load ? 1'b1 : buf_full_q);
    buf_addr_d  = buf_load ? ioctl_addr : buf_addr_q;
    buf_data_d  = buf_load ? ioctl_dout : buf_data_q;
    // Stall the loader whenever a buffered byte cannot leave or another byte arrives.
    wait_d      = buf_full_q & (core_rd | ioctl_wr);
    data_p2_d   = rd_p1_q ? mem_dout : data_p2_q;
    case (state_q)
      ST_IDLE: begin
        if (start_load) begin
          state_d     = ST_LOAD;
          rise_pend_d = 1'b0;
          tracker_d   = '0;
          size_d      = '0;
        end
      end
      ST_LOAD: begin
        if (!ioctl_download) state_d = ST_DRAIN;
      end
      ST_DRAIN: begin
        // A new session requested mid-drain is remembered and started from IDLE.
        if (dl_rise) rise_pend_d = 1'b1;
        if (!buf_full_q) begin
          state_d = ST_IDLE;
          size_d  = tracker_q;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= ST_IDLE;
      dl_q        <= 1'b0;
      rise_pend_q <= 1'b0;
      buf_full_q  <= 1'b0;
      wait_q      <= 1'b0;
      rd_p1_q     <= 1'b0;
      vld_p2_q    <= 1'b0;
      data_p2_q   <= '0;
      tracker_q   <= '0;
      size_q      <= '0;
    end else begin
      state_q     <= state_d;
      dl_q        <= ioctl_download;
      rise_pend_q <= rise_pend_d;
      buf_full_q  <= buf_full_d;
      wait_q      <= wait_d;
      // p1: BRAM output becomes valid; p2: captured for the core.
      rd_p1_q     <= core_rd;
      vld_p2_q    <= rd_p1_q;
      data_p2_q   <= data_p2_d;
      tracker_q   <= tracker_d;
      size_q      <= size_d;
    end
  end

  always_ff @(posedge clk_sys) begin
    buf_addr_q <= buf_addr_d;
    buf_data_q <= buf_data_d;
  end

`ifdef CART_CHECKSUM_EN
  logic [15:0] sum_q, sum_d;

  always_comb begin
    sum_d = sum_q;
    if (start_load) sum_d = '0;
    else if (commit) sum_d = sum_q + 16'(buf_data_q);
  end

  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) sum_q <= '0;
    else          sum_q <= sum_d;
  end

  assign cart_sum = sum_q;
`else
  assign cart_sum = 16'h0000;
`endif

  assign ioctl_wait = wait_q;
  assign core_valid = vld_p2_q;
  assign core_data  = data_p2_q;
  assign cart_size  = size_q;
  assign loading    = (state_q != ST_IDLE);

endmodule
